// File: rtl/interface_pkg.sv
// Shared definitions for the UART-to-ALU interface blocks (receive and transmit sides):
// FSM state encoding and the byte-count helper.
package interface_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Number of UART bytes needed to carry nb_result bits, never less than one.
  function automatic int unsigned nb_bytes(input int unsigned nb_result,
                                           input int unsigned nb_data);
    int unsigned n;
    n = (nb_result + nb_data - 1) / nb_data;
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/result_tx_interface.sv
// Captures one ALU result and streams it LSB byte first to the UART TX via start/done.
// Optional trailing XOR checksum byte when RESULT_TX_CHECKSUM_EN is defined.
module result_tx_interface
  import interface_pkg::*;
#(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_RESULT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NB_RESULT-1:0] i_result,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy
);

  localparam int unsigned NB_BYTES = nb_bytes(NB_RESULT, NB_DATA);
  localparam int unsigned NB_SHIFT = NB_BYTES * NB_DATA;
  localparam int unsigned NB_CNT   = $clog2(NB_BYTES + 1);
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(NB_BYTES - 1);

  logic [1:0]          state_q, state_d;
  logic [NB_SHIFT-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [NB_DATA-1:0] chk_q, chk_d;
  logic               chk_phase;

  // byte_cnt == NB_BYTES marks the trailing checksum byte
  assign chk_phase = (cnt_q == NB_CNT'(NB_BYTES));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef RESULT_TX_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    o_tx_start = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          shift_d = NB_SHIFT'(i_result);
          cnt_d   = '0;
`ifdef RESULT_TX_CHECKSUM_EN
          chk_d   = '0;
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        o_tx_start = 1'b1;
        state_d    = ST_WAIT;
`ifdef RESULT_TX_CHECKSUM_EN
        if (!chk_phase) chk_d = chk_q ^ shift_q[NB_DATA-1:0];
`endif
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (cnt_q < LAST_CNT) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = shift_q >> NB_DATA;
            state_d = ST_START;
          end else begin
`ifdef RESULT_TX_CHECKSUM_EN
            if (!chk_phase) begin
              cnt_d   = cnt_q + 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RESULT_TX_CHECKSUM_EN
  assign o_tx_data = chk_phase ? chk_q : shift_q[NB_DATA-1:0];
`else
  assign o_tx_data = shift_q[NB_DATA-1:0];
`endif

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = ~o_ready;

endmodule
